// File: rtl/inst_feeder_pkg.sv
// Shared types and defaults for the instruction feeder.
// Optional single-step state is present only with INST_FEEDER_SINGLE_STEP_EN.
package inst_feeder_pkg;

  localparam int          DW_DEF        = 16;
  localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_LOAD,
    ST_ISSUE,
    ST_EXEC,
    ST_HALTED
`ifdef INST_FEEDER_SINGLE_STEP_EN
    , ST_STEP
`endif
  } state_e;

endpackage

// File: rtl/inst_feeder_if.sv
// ROM-side and processor-side signals of the feeder; master = feeder, slave = ROM/proc/top.
// Step exists only with INST_FEEDER_SINGLE_STEP_EN.
interface inst_feeder_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic          Start;
  logic          Done;
  logic [DW-1:0] mem_q;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] DIN;
  logic          Run;
  logic [AW-1:0] pc;
  logic          Halted;
  logic [15:0]   instr_count;
`ifdef INST_FEEDER_SINGLE_STEP_EN
  logic          Step;
`endif

  modport master (
`ifdef INST_FEEDER_SINGLE_STEP_EN
    input  Step,
`endif
    input  Start, Done, mem_q,
    output mem_addr, DIN, Run, pc, Halted, instr_count
  );

  modport slave (
`ifdef INST_FEEDER_SINGLE_STEP_EN
    output Step,
`endif
    output Start, Done, mem_q,
    input  mem_addr, DIN, Run, pc, Halted, instr_count
  );
endinterface

// File: rtl/inst_feeder_pc_counter.sv
// AW-bit program counter: synchronous active-low clear, increment enable, wraps modulo 2^AW.
module pc_counter #(
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          clr_n_i,
  input  logic          inc_i,
  output logic [AW-1:0] count_o
);
  logic [AW-1:0] count_q;
  logic [AW-1:0] count_d;

  assign count_d = count_q + AW'(1);
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/inst_feeder.sv
// Fetches words from a sync-read ROM, issues them to the processor with a one-cycle Run, waits for Done.
// Optional INST_FEEDER_SINGLE_STEP_EN: after each Done, hold in STEP until a Step pulse.
module inst_feeder
  import inst_feeder_pkg::*;
#(
  parameter int            AW        = 5,
  parameter int            DW        = DW_DEF,
  parameter logic [DW-1:0] HALT_WORD = DW'(HALT_WORD_DEF)
) (
  input logic            Clock,
  input logic            Resetn,
  inst_feeder_if.master  bus
);
  state_e        state_q;
  logic [DW-1:0] din_q;
  logic          run_q;
  logic          halted_q;
  logic [15:0]   cnt_q;
  logic [15:0]   cnt_d;
  logic          pc_inc;
  logic [AW-1:0] pc;

  assign pc_inc = (state_q == ST_EXEC) && bus.Done;
  assign cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  pc_counter #(.AW(AW)) u_pc (
    .clk_i   (Clock),
    .clr_n_i (Resetn),
    .inc_i   (pc_inc),
    .count_o (pc)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= ST_IDLE;
      din_q    <= '0;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      run_q <= 1'b0;
      case (state_q)
        ST_IDLE:  if (bus.Start) state_q <= ST_ADDR;
        ST_ADDR:  state_q <= ST_WAIT;
        ST_WAIT:  state_q <= ST_LOAD;
        ST_LOAD: begin
          // The halt word is swallowed: DIN keeps the last real instruction.
          if (bus.mem_q == HALT_WORD) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            din_q   <= bus.mem_q;
            run_q   <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_EXEC;
        ST_EXEC: begin
          if (bus.Done) begin
            cnt_q <= cnt_d;
`ifdef INST_FEEDER_SINGLE_STEP_EN
            state_q <= ST_STEP;
`else
            state_q <= ST_ADDR;
`endif
          end
        end
        ST_HALTED: halted_q <= 1'b1;
`ifdef INST_FEEDER_SINGLE_STEP_EN
        ST_STEP:  if (bus.Step) state_q <= ST_ADDR;
`endif
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_addr    = pc;
  assign bus.pc          = pc;
  assign bus.DIN         = din_q;
  assign bus.Run         = run_q;
  assign bus.Halted      = halted_q;
  assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_inst_feeder.sv
// Directed bench for inst_feeder: cycle table for a short program plus hand-written corner sequences.
module tb_inst_feeder;
  import inst_feeder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_feeder_if #(.AW(5), .DW(16)) bus ();
  inst_feeder_if #(.AW(2), .DW(16)) bus2 ();

  inst_feeder #(.AW(5)) u_dut  (.Clock(clk), .Resetn(rst_n), .bus(bus));
  inst_feeder #(.AW(2)) u_dut2 (.Clock(clk), .Resetn(rst_n), .bus(bus2));

  logic [15:0] rom [32];
  always @(posedge clk) bus.mem_q  <= rom[bus.mem_addr];
  always @(posedge clk) bus2.mem_q <= 16'h0005;

  typedef struct {
    logic        start;
    logic        done;
    logic        run;
    logic [15:0] din;
    logic [4:0]  pc;
    logic        halted;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [17];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input string name, input int max, output int cyc);
    cyc = 0;
    while (bus.Run !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
    if (bus.Run !== 1'b1) chk(name, {31'd0, bus.Run}, 32'd1);
  endtask

  // Called with the feeder in ISSUE; returns with it back in ADDR.
  task automatic finish_instr();
    tick();
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
`ifdef INST_FEEDER_SINGLE_STEP_EN
    bus.Step = 1'b1;
    tick();
    bus.Step = 1'b0;
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int nrun;
    int nbad;
    bus.Start = 1'b0;  bus.Done = 1'b0;
    bus2.Start = 1'b0; bus2.Done = 1'b0;
`ifdef INST_FEEDER_SINGLE_STEP_EN
    bus.Step = 1'b0; bus2.Step = 1'b0;
`endif
    for (int i = 0; i < 32; i++) rom[i] = 16'h0005;

    // ---------------- reset state and reset mid-EXEC ----------------
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h1234;
    tick(); tick();
    chk("rst_run", {31'd0, bus.Run}, 32'd0);
    chk("rst_pc", {27'd0, bus.pc}, 32'd0);
    chk("rst_din", {16'd0, bus.DIN}, 32'd0);
    chk("rst_halted", {31'd0, bus.Halted}, 32'd0);
    chk("rst_cnt", {16'd0, bus.instr_count}, 32'd0);
    rst_n = 1'b1;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_run("mid_run", 10, cyc);
      finish_instr();
    end
    wait_run("mid_run3", 10, cyc);
    tick();
    chk("mid_din", {16'd0, bus.DIN}, 32'h1234);
    chk("mid_pc", {27'd0, bus.pc}, 32'd3);
    chk("mid_cnt", {16'd0, bus.instr_count}, 32'd3);
    chk("mid_state", {29'd0, u_dut.state_q}, {29'd0, ST_EXEC});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_run", {31'd0, bus.Run}, 32'd0);
    chk("mrst_pc", {27'd0, bus.pc}, 32'd0);
    chk("mrst_din", {16'd0, bus.DIN}, 32'd0);
    chk("mrst_cnt", {16'd0, bus.instr_count}, 32'd0);
    chk("mrst_state", {29'd0, u_dut.state_q}, {29'd0, ST_IDLE});
    nrun = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.Run === 1'b1) nrun++;
    end
    chk("mrst_stay_idle", nrun, 0);

`ifndef INST_FEEDER_SINGLE_STEP_EN
    // ---------------- table: 0001, 0002, halt; Done two cycles after Run ----------------
    rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'hFFFF;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 5'd0, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 5'd0, 1'b0, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 5'd0, 1'b0, 16'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0001, 5'd1, 1'b0, 16'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 5'd1, 1'b0, 16'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 5'd1, 1'b0, 16'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 5'd1, 1'b0, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0002, 5'd1, 1'b0, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0002, 5'd1, 1'b0, 16'd1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0002, 5'd2, 1'b0, 16'd2};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h0002, 5'd2, 1'b0, 16'd2};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 16'h0002, 5'd2, 1'b0, 16'd2};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 16'h0002, 5'd2, 1'b1, 16'd2};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 16'h0002, 5'd2, 1'b1, 16'd2};
    nrun = 0;
    for (int i = 0; i < 17; i++) begin
      bus.Start = tbl[i].start;
      bus.Done  = tbl[i].done;
      tick();
      if (bus.Run === 1'b1) nrun++;
      chk($sformatf("tbl%0d_run", i), {31'd0, bus.Run}, {31'd0, tbl[i].run});
      chk($sformatf("tbl%0d_din", i), {16'd0, bus.DIN}, {16'd0, tbl[i].din});
      chk($sformatf("tbl%0d_pc", i), {27'd0, bus.pc}, {27'd0, tbl[i].pc});
      chk($sformatf("tbl%0d_addr", i), {27'd0, bus.mem_addr}, {27'd0, tbl[i].pc});
      chk($sformatf("tbl%0d_halted", i), {31'd0, bus.Halted}, {31'd0, tbl[i].halted});
      chk($sformatf("tbl%0d_cnt", i), {16'd0, bus.instr_count}, {16'd0, tbl[i].cnt});
    end
    bus.Start = 1'b0; bus.Done = 1'b0;
    chk("tbl_run_pulses", nrun, 2);

    // ---------------- latency with Start held, 1-cycle instruction ----------------
    rom[0] = 16'h0011; rom[1] = 16'h0022; rom[2] = 16'h0033;
    rst_n = 1'b0;
    bus.Start = 1'b1;
    tick();
    rst_n = 1'b1;
    wait_run("lat_start", 20, cyc);
    chk("start_to_run", cyc, 4);
    tick();
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    wait_run("lat_done", 20, cyc);
    chk("done_to_run", cyc + 1, 4);
    chk("lat_din", {16'd0, bus.DIN}, 32'h0022);

    // ---------------- Done withheld, then Done outside EXEC ----------------
    bus.Start = 1'b0;
    nrun = 0; nbad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.Run === 1'b1) nrun++;
      if (bus.DIN !== 16'h0022 || bus.pc !== 5'd1) nbad++;
    end
    chk("hold_no_run", nrun, 0);
    chk("hold_din_pc", nbad, 0);
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    chk("hold_pc_adv", {27'd0, bus.pc}, 32'd2);
    tick();
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    chk("wait_done_pc", {27'd0, bus.pc}, 32'd2);
    chk("wait_done_cnt", {16'd0, bus.instr_count}, 32'd2);
    tick();
    chk("wait_done_run", {31'd0, bus.Run}, 32'd1);
    chk("wait_done_din", {16'd0, bus.DIN}, 32'h0033);
`endif

    // ---------------- AW=2 instance: pc wraps 3 -> 0 ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus2.Start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      while (bus2.Run !== 1'b1 && cyc < 10) begin tick(); cyc++; end
      chk($sformatf("wrap%0d_run", i), {31'd0, bus2.Run}, 32'd1);
      chk($sformatf("wrap%0d_din", i), {16'd0, bus2.DIN}, 32'h0005);
      tick();
      bus2.Done = 1'b1;
      tick();
      bus2.Done = 1'b0;
`ifdef INST_FEEDER_SINGLE_STEP_EN
      bus2.Step = 1'b1;
      tick();
      bus2.Step = 1'b0;
`endif
      chk($sformatf("wrap%0d_pc", i), {30'd0, bus2.pc}, (i + 1) % 4);
    end
    chk("wrap_cnt", {16'd0, bus2.instr_count}, 32'd4);
    cyc = 0;
    while (bus2.Run !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    chk("wrap_continue", {31'd0, bus2.Run}, 32'd1);
    bus2.Start = 1'b0;

`ifdef INST_FEEDER_SINGLE_STEP_EN
    // ---------------- single-step ----------------
    rom[0] = 16'h0011; rom[1] = 16'h0022; rom[2] = 16'h0033;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    wait_run("step_first", 10, cyc);
    tick();
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    chk("step_pc", {27'd0, bus.pc}, 32'd1);
    chk("step_cnt", {16'd0, bus.instr_count}, 32'd1);
    nrun = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.Run === 1'b1) nrun++;
    end
    chk("step_hold_no_run", nrun, 0);
    chk("step_state", {29'd0, u_dut.state_q}, {29'd0, ST_STEP});
    bus.Step = 1'b1;
    tick();
    bus.Step = 1'b0;
    wait_run("step_go", 10, cyc);
    chk("step_to_run", cyc + 1, 4);
    chk("step_din", {16'd0, bus.DIN}, 32'h0022);
    tick();
    bus.Step = 1'b1;
    tick();
    bus.Step = 1'b0;
    chk("step_in_exec", {29'd0, u_dut.state_q}, {29'd0, ST_EXEC});
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    nrun = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.Run === 1'b1) nrun++;
    end
    chk("step_exec_ignored", nrun, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("step_rst_state", {29'd0, u_dut.state_q}, {29'd0, ST_IDLE});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
